// File: rtl/a5_keystream_engine.sv
// A5/1 keystream engine: key/frame setup, mixing, then a burst of keystream
// bits packed LSB-first into OUT_WIDTH-bit words on a valid/ready stream.
module a5_keystream_engine #(
  parameter int KEY_BITS   = 64,
  parameter int FRAME_BITS = 22,
  parameter int MIX_CYCLES = 100,
  parameter int OUT_WIDTH  = 8,
  parameter int BURST_BITS = 228
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic                  abort,
  input  logic [KEY_BITS-1:0]   key,
  input  logic [FRAME_BITS-1:0] frame,
  output logic                  busy,
  output logic [OUT_WIDTH-1:0]  out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  out_last
);

  localparam int LOAD_CYCLES = KEY_BITS + FRAME_BITS;
  localparam int PH_MAX      = (LOAD_CYCLES > MIX_CYCLES) ? LOAD_CYCLES : MIX_CYCLES;
  localparam int PW          = $clog2(PH_MAX + 1);
  localparam int BW          = $clog2(BURST_BITS + 1);
  localparam int WW          = $clog2(OUT_WIDTH + 1);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_MIX, S_RUN, S_DRAIN} state_t;

  state_t                 state, state_n;
  logic [18:0]            r1, r1_n, r1_maj;
  logic [21:0]            r2, r2_n, r2_maj;
  logic [22:0]            r3, r3_n, r3_maj;
  logic [LOAD_CYCLES-1:0] load_sr, load_sr_n;
  logic [PW-1:0]          phase_cnt, phase_cnt_n;
  logic [BW-1:0]          bit_cnt, bit_cnt_n, bit_next;
  logic [WW-1:0]          word_idx, word_idx_n, widx_next;
  logic [OUT_WIDTH-1:0]   acc, acc_n, out_data_n;
  logic                   acc_full, acc_full_n, acc_last, acc_last_n;
  logic                   out_valid_n, out_last_n;
  logic                   maj, ks_bit, can_xfer, gen, burst_end, word_end;

  function automatic logic [18:0] step_r1(input logic [18:0] r);
    return {r[17:0], r[18] ^ r[17] ^ r[16] ^ r[13]};
  endfunction

  function automatic logic [21:0] step_r2(input logic [21:0] r);
    return {r[20:0], r[21] ^ r[20]};
  endfunction

  function automatic logic [22:0] step_r3(input logic [22:0] r);
    return {r[21:0], r[22] ^ r[21] ^ r[20] ^ r[7]};
  endfunction

  // Majority-clocked successors and the keystream bit they produce.
  always_comb begin
    maj    = (r1[8] & r2[10]) | (r1[8] & r3[10]) | (r2[10] & r3[10]);
    r1_maj = (r1[8]  == maj) ? step_r1(r1) : r1;
    r2_maj = (r2[10] == maj) ? step_r2(r2) : r2;
    r3_maj = (r3[10] == maj) ? step_r3(r3) : r3;
    ks_bit = r1_maj[18] ^ r2_maj[21] ^ r3_maj[22];
  end

  always_comb begin
    // NOTE: every signal written here gets a default first so no latch is inferred.
    state_n     = state;
    r1_n        = r1;
    r2_n        = r2;
    r3_n        = r3;
    load_sr_n   = load_sr;
    phase_cnt_n = phase_cnt;
    bit_cnt_n   = bit_cnt;
    word_idx_n  = word_idx;
    acc_n       = acc;
    acc_full_n  = acc_full;
    acc_last_n  = acc_last;
    out_data_n  = out_data;
    out_valid_n = out_valid;
    out_last_n  = out_last;

    // A finished word moves out whenever the output register is free or being drained.
    can_xfer  = acc_full && (!out_valid || out_ready);
    gen       = (state == S_RUN) && (!acc_full || can_xfer);
    bit_next  = bit_cnt + 1'b1;
    widx_next = word_idx + 1'b1;
    burst_end = (bit_next == BW'(BURST_BITS));
    word_end  = (widx_next == WW'(OUT_WIDTH));

    if (can_xfer) begin
      out_data_n  = acc;
      out_valid_n = 1'b1;
      out_last_n  = acc_last;
      acc_full_n  = 1'b0;
      acc_n       = '0;
    end else if (out_valid && out_ready) begin
      out_valid_n = 1'b0;
      out_last_n  = 1'b0;
    end

    case (state)
      S_IDLE: begin
        if (start) begin
          state_n     = S_LOAD;
          load_sr_n   = {frame, key};
          r1_n        = '0;
          r2_n        = '0;
          r3_n        = '0;
          phase_cnt_n = '0;
          bit_cnt_n   = '0;
          word_idx_n  = '0;
          acc_n       = '0;
          acc_full_n  = 1'b0;
          acc_last_n  = 1'b0;
        end
      end
      S_LOAD: begin
        r1_n        = step_r1(r1) ^ {18'b0, load_sr[0]};
        r2_n        = step_r2(r2) ^ {21'b0, load_sr[0]};
        r3_n        = step_r3(r3) ^ {22'b0, load_sr[0]};
        load_sr_n   = load_sr >> 1;
        phase_cnt_n = phase_cnt + 1'b1;
        if (phase_cnt == PW'(LOAD_CYCLES - 1)) begin
          state_n     = S_MIX;
          phase_cnt_n = '0;
        end
      end
      S_MIX: begin
        r1_n        = r1_maj;
        r2_n        = r2_maj;
        r3_n        = r3_maj;
        phase_cnt_n = phase_cnt + 1'b1;
        if (phase_cnt == PW'(MIX_CYCLES - 1)) begin
          state_n     = S_RUN;
          phase_cnt_n = '0;
        end
      end
      S_RUN: begin
        if (gen) begin
          r1_n      = r1_maj;
          r2_n      = r2_maj;
          r3_n      = r3_maj;
          acc_n     = acc_n | (OUT_WIDTH'(ks_bit) << word_idx);
          bit_cnt_n = bit_next;
          if (word_end || burst_end) begin
            acc_full_n = 1'b1;
            acc_last_n = burst_end;
            word_idx_n = '0;
          end else begin
            word_idx_n = widx_next;
          end
          if (burst_end) state_n = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (out_valid && out_ready && out_last) state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase

    if (abort) begin
      state_n     = S_IDLE;
      phase_cnt_n = '0;
      bit_cnt_n   = '0;
      word_idx_n  = '0;
      acc_n       = '0;
      acc_full_n  = 1'b0;
      acc_last_n  = 1'b0;
      out_data_n  = '0;
      out_valid_n = 1'b0;
      out_last_n  = 1'b0;
    end
  end

  // NOTE: state registers use non-blocking assignments; the combinational block uses blocking.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= S_IDLE;
      r1        <= '0;
      r2        <= '0;
      r3        <= '0;
      load_sr   <= '0;
      phase_cnt <= '0;
      bit_cnt   <= '0;
      word_idx  <= '0;
      acc       <= '0;
      acc_full  <= 1'b0;
      acc_last  <= 1'b0;
      out_data  <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
    end else begin
      state     <= state_n;
      r1        <= r1_n;
      r2        <= r2_n;
      r3        <= r3_n;
      load_sr   <= load_sr_n;
      phase_cnt <= phase_cnt_n;
      bit_cnt   <= bit_cnt_n;
      word_idx  <= word_idx_n;
      acc       <= acc_n;
      acc_full  <= acc_full_n;
      acc_last  <= acc_last_n;
      out_data  <= out_data_n;
      out_valid <= out_valid_n;
      out_last  <= out_last_n;
    end
  end

  assign busy = (state != S_IDLE);

endmodule

// File: tb/tb_a5_keystream_engine.sv
// Self-checking bench for a5_keystream_engine: golden vector, backpressure,
// control edges, async reset and a parameter sweep against an A5/1 model.
module tb_a5_keystream_engine;

  localparam logic [63:0] GOLD_KEY   = 64'hEFCDAB8967452312;
  localparam logic [21:0] GOLD_FRAME = 22'h134;
  localparam int          NSW        = 4;
  localparam int          SW_W [NSW] = '{1, 5, 32, 32};
  localparam int          SW_B [NSW] = '{114, 228, 1, 228};
  localparam int          SW_M [NSW] = '{1, 100, 1, 100};

  logic        clk = 1'b0;
  logic        reset_n, start, abort, out_ready, busy, out_valid, out_last;
  logic [63:0] key;
  logic [21:0] frame;
  logic [7:0]  out_data;
  logic        sw_start, sw_ready, sw_abort;
  logic [NSW-1:0] sw_busy;
  int          sw_words [NSW];
  int          sw_mis   [NSW];
  int          sw_lerr  [NSW];

  int          n_checks = 0;
  int          n_bad    = 0;
  bit          ks_ref [3][1024];
  bit          got_q [$];
  logic [7:0]  got_w [$];
  int          first_lat;

  always #5 clk = ~clk;

  a5_keystream_engine #(
    .KEY_BITS(64), .FRAME_BITS(22), .MIX_CYCLES(100), .OUT_WIDTH(8), .BURST_BITS(228)
  ) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .abort(abort), .key(key), .frame(frame),
    .busy(busy), .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_last(out_last)
  );

  for (genvar g = 0; g < NSW; g++) begin : g_sw
    localparam int W   = SW_W[g];
    localparam int B   = SW_B[g];
    localparam int SEL = (SW_M[g] == 1) ? 2 : 1;
    logic [W-1:0] d;
    logic         v, l;
    int           nbits = 0, nwords = 0, nmis = 0, nlast = 0;

    a5_keystream_engine #(
      .KEY_BITS(64), .FRAME_BITS(22), .MIX_CYCLES(SW_M[g]), .OUT_WIDTH(W), .BURST_BITS(B)
    ) u_dut (
      .clk(clk), .reset_n(reset_n), .start(sw_start), .abort(sw_abort), .key(key), .frame(frame),
      .busy(sw_busy[g]), .out_data(d), .out_valid(v), .out_ready(sw_ready), .out_last(l)
    );

    always @(negedge clk) begin
      if (v && sw_ready) begin
        for (int i = 0; i < W; i++) begin
          if (nbits + i < B) begin
            if (d[i] != ks_ref[SEL][nbits + i]) nmis++;
          end else if (d[i] != 1'b0) begin
            nmis++;
          end
        end
        if (l != (nbits + W >= B)) nlast++;
        nbits  = (nbits + W >= B) ? B : nbits + W;
        nwords++;
      end
    end

    assign sw_words[g] = nwords;
    assign sw_mis[g]   = nmis;
    assign sw_lerr[g]  = nlast;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Reference A5/1 written with plain integer masks, as in the published C model.
  localparam int unsigned M_LEN [3] = '{19, 22, 23};
  localparam int unsigned M_TAP [3] = '{32'h072000, 32'h300000, 32'h700080};
  localparam int unsigned M_CB  [3] = '{8, 10, 10};

  function automatic int unsigned m_clock(input int unsigned x, input int i);
    int unsigned p;
    p = $countones(x & M_TAP[i]) & 1;
    return ((x << 1) | p) & ((32'd1 << M_LEN[i]) - 1);
  endfunction

  task automatic model_run(input int sel, input logic [63:0] k, input logic [21:0] f,
                           input int mix, input int n);
    int unsigned r [3];
    int unsigned b, m;
    r = '{0, 0, 0};
    for (int t = 0; t < 86; t++) begin
      b = (t < 64) ? 32'(k[t]) : 32'(f[t - 64]);
      for (int i = 0; i < 3; i++) r[i] = m_clock(r[i], i) ^ b;
    end
    for (int t = 0; t < mix + n; t++) begin
      m = ((((r[0] >> 8) & 1) + ((r[1] >> 10) & 1) + ((r[2] >> 10) & 1)) >= 2) ? 1 : 0;
      for (int i = 0; i < 3; i++)
        if (((r[i] >> M_CB[i]) & 1) == m) r[i] = m_clock(r[i], i);
      if (t >= mix) ks_ref[sel][t - mix] = bit'(((r[0] >> 18) ^ (r[1] >> 21) ^ (r[2] >> 22)) & 1);
    end
  endtask

  function automatic int count_mis(input int n);
    int c = 0;
    for (int i = 0; i < n; i++)
      if (i >= got_q.size() || got_q[i] != ks_ref[0][i]) c++;
    return c;
  endfunction

  // Runs one default-parameter burst; optionally pokes start (with a different key) mid-burst.
  task automatic run_main(input logic [63:0] k, input logic [21:0] f, input int ready_pct,
                          input int poke_at);
    bit         held = 0, fin = 0;
    logic [7:0] held_data = '0;
    logic       held_last = 1'b0;
    int         nb;
    got_q.delete();
    got_w.delete();
    first_lat = -1;
    key = k; frame = f; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    for (int c = 0; c < 3000 && !fin; c++) begin
      out_ready = ($urandom_range(99) < ready_pct);
      if (c == poke_at) begin start = 1'b1; key = ~k; end
      else if (c == poke_at + 1) begin start = 1'b0; key = k; end
      @(negedge clk);
      if (held) begin
        check("hold_valid", out_valid, 1'b1);
        check("hold_data", out_data, held_data);
        check("hold_last", out_last, held_last);
      end
      if (out_valid && first_lat < 0) first_lat = c;
      held      = out_valid && !out_ready;
      held_data = out_data;
      held_last = out_last;
      if (out_valid && out_ready) begin
        nb = (228 - got_q.size() < 8) ? 228 - got_q.size() : 8;
        if (nb < 0) nb = 0;
        got_w.push_back(out_data);
        for (int b = 0; b < nb; b++) got_q.push_back(out_data[b]);
        check("out_last", out_last, got_q.size() >= 228);
        if (out_last || got_q.size() >= 228) begin
          check("last_pad", out_data >> nb, 0);
          check("busy_at_last", busy, 1'b1);
          fin = 1;
        end
      end
      @(posedge clk); #1;
    end
    start = 1'b0;
    key   = k;
    check("burst_done", fin, 1'b1);
    @(negedge clk);
    check("busy_drop", busy, 1'b0);
    check("valid_drop", out_valid, 1'b0);
  endtask

  task automatic abort_test(input string tag, input int n, input bit rdy);
    key = GOLD_KEY; frame = GOLD_FRAME; out_ready = rdy; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (n) @(posedge clk);
    #1;
    if (!rdy) check({tag, "_pre_valid"}, out_valid, 1'b1);
    abort = 1'b1;
    @(posedge clk); #1 abort = 1'b0;
    check({tag, "_busy"}, busy, 1'b0);
    check({tag, "_valid"}, out_valid, 1'b0);
    check({tag, "_last"}, out_last, 1'b0);
    out_ready = 1'b1;
  endtask

  task automatic golden_stream(input string tag);
    run_main(GOLD_KEY, GOLD_FRAME, 100, -1);
    check({tag, "_mis"}, count_mis(228), 0);
    check({tag, "_words"}, got_w.size(), 29);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [119:0] gold_bytes;
    logic [7:0]   gb;
    logic [63:0]  rk;
    logic [21:0]  rf;
    reset_n = 1'b0; start = 1'b0; abort = 1'b0; out_ready = 1'b0;
    key = '0; frame = '0; sw_start = 1'b0; sw_ready = 1'b0; sw_abort = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", busy, 1'b0);
    check("rst_valid", out_valid, 1'b0);
    check("rst_last", out_last, 1'b0);
    check("rst_data", out_data, 8'h00);
    reset_n = 1'b1;
    @(posedge clk); #1;

    // Golden vector
    model_run(0, GOLD_KEY, GOLD_FRAME, 100, 228);
    run_main(GOLD_KEY, GOLD_FRAME, 100, -1);
    check("gold_latency", first_lat, 195);
    check("gold_word0", got_w.size() > 0 ? got_w[0] : 8'hxx, 8'hCA);
    check("gold_word1", got_w.size() > 1 ? got_w[1] : 8'hxx, 8'h72);
    check("gold_words", got_w.size(), 29);
    check("gold_last_hi", got_w.size() > 28 ? 4'(got_w[28] >> 4) : 4'hx, 4'h0);
    gold_bytes = 120'h534EAA582FE8151AB6E1855A728C00;
    for (int j = 0; j < 15; j++) begin
      gb = '0;
      for (int b = 0; b < 8; b++)
        if (j * 8 + b < 114 && j * 8 + b < got_q.size()) gb[7 - b] = got_q[j * 8 + b];
      check($sformatf("gold_byte%0d", j), gb, gold_bytes[119 - 8 * j -: 8]);
    end
    check("gold_mis", count_mis(228), 0);

    // Backpressure with a random key
    rk = {$urandom, $urandom};
    rf = 22'($urandom);
    model_run(0, rk, rf, 100, 228);
    run_main(rk, rf, 30, -1);
    check("bp_mis", count_mis(228), 0);
    check("bp_words", got_w.size(), 29);

    // start while busy must be ignored
    model_run(0, GOLD_KEY, GOLD_FRAME, 100, 228);
    run_main(GOLD_KEY, GOLD_FRAME, 100, 50);
    check("poke_load_mis", count_mis(228), 0);
    run_main(GOLD_KEY, GOLD_FRAME, 60, 220);
    check("poke_run_mis", count_mis(228), 0);

    // abort in each phase, and abort beating start
    abort_test("abort_load", 10, 1'b1);
    abort_test("abort_mix", 120, 1'b1);
    abort_test("abort_run", 200, 1'b0);
    start = 1'b1; abort = 1'b1;
    @(posedge clk); #1 start = 1'b0; abort = 1'b0;
    check("abort_vs_start", busy, 1'b0);
    golden_stream("post_abort");

    // asynchronous reset mid-run with a word held
    key = GOLD_KEY; frame = GOLD_FRAME; out_ready = 1'b0; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (200) @(posedge clk);
    #1;
    check("rst_mid_pre_valid", out_valid, 1'b1);
    #2 reset_n = 1'b0;
    #1;
    check("rst_mid_valid", out_valid, 1'b0);
    check("rst_mid_data", out_data, 8'h00);
    check("rst_mid_last", out_last, 1'b0);
    check("rst_mid_busy", busy, 1'b0);
    @(posedge clk); #1 reset_n = 1'b1;
    @(posedge clk); #1;
    golden_stream("post_reset");

    // Parameter sweep
    rk = {$urandom, $urandom};
    rf = 22'($urandom);
    key = rk; frame = rf;
    model_run(1, rk, rf, 100, 228);
    model_run(2, rk, rf, 1, 228);
    sw_ready = 1'b1; sw_start = 1'b1;
    @(posedge clk); #1 sw_start = 1'b0;
    check("sw_busy", sw_busy, {NSW{1'b1}});
    for (int c = 0; c < 6000 && sw_busy != '0; c++) begin
      sw_ready = 1'($urandom_range(1));
      @(posedge clk); #1;
    end
    check("sw_idle", sw_busy, '0);
    for (int i = 0; i < NSW; i++) begin
      check($sformatf("sw%0d_mis", i), sw_mis[i], 0);
      check($sformatf("sw%0d_last", i), sw_lerr[i], 0);
      check($sformatf("sw%0d_words", i), sw_words[i], (SW_B[i] + SW_W[i] - 1) / SW_W[i]);
    end

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule

// File: doc/a5_keystream_engine.md
Name: a5_keystream_engine

Overview:
- Parametrised A5/1 keystream engine that generates complete bursts.
- Loads a key and frame number, runs the three-LFSR A5/1 key setup and the mixing phase, then generates BURST_BITS keystream bits.
- Keystream bits are packed into OUT_WIDTH-bit words and delivered over a valid/ready stream with backpressure and an end-of-burst marker.
- Sits between the session-key register block and the burst cipher XOR datapath.

Parameters:
- KEY_BITS, 64, key length; fed LSB first.
- FRAME_BITS, 22, frame-number length; fed LSB first.
- MIX_CYCLES, 100, majority-clocked steps with output discarded (must be ≥1).
- OUT_WIDTH, 8, output word width, 1..32.
- BURST_BITS, 228, keystream bits per start (1..1023); need not be a multiple of OUT_WIDTH.

Ports:
- clk  in  1  clock.
- reset_n  in  1  asynchronous active-low reset.
- start  in  1  begin a burst; sampled only when busy=0.
- abort  in  1  synchronous cancel of any operation in progress.
- key  in  KEY_BITS  session key; captured on an accepted start.
- frame  in  FRAME_BITS  frame number; captured on an accepted start.
- busy  out  1  high from the cycle after an accepted start until the last word handshake.
- out_data  out  OUT_WIDTH  keystream word; first-generated bit in bit 0.
- out_valid  out  1  out_data is valid.
- out_ready  in  1  consumer accepts the word when out_valid & out_ready.
- out_last  out  1  qualifies the final word of a burst.

Behaviour:
- Reset is asynchronous, active-low, clock clk. On reset: state IDLE; R1/R2/R3, accumulator and counters = 0; busy=0, out_valid=0, out_last=0, out_data=0.
- Registers and polynomials are fixed:
  - R1: 19 bits, taps 18,17,16,13, clock bit 8.
  - R2: 22 bits, taps 21,20, clock bit 10.
  - R3: 23 bits, taps 22,21,20,7, clock bit 10.
  - Clocking a register shifts it left by one and writes the XOR of its taps into bit 0.
- Majority = maj(R1[8], R2[10], R3[10]). A register clocks iff its clock bit equals the majority.
- Keystream bit = R1[18]^R2[21]^R3[22], sampled after that cycle's clocking.
- FSM:
  - IDLE: start & !abort → capture key/frame, zero R1–R3, go to LOAD. start while busy is ignored.
  - LOAD, KEY_BITS+FRAME_BITS cycles: all three registers clock unconditionally, then bit 0 ^= input bit. Input bits are key[0..KEY_BITS-1], then frame[0..FRAME_BITS-1].
  - MIX, MIX_CYCLES cycles: majority clocking; output discarded.
  - RUN: one majority step plus one keystream bit per cycle unless stalled. Bit n goes to accumulator bit (n mod OUT_WIDTH).
    - A word completes when OUT_WIDTH bits are collected or the burst bit count reaches BURST_BITS.
    - The word transfers to the output register in the following cycle, with out_valid=1.
    - The final word has out_last=1, and its unused high bits are 0.
    - Stall: if a word is complete and the output register is still held (out_valid & !out_ready), LFSRs and accumulator freeze. No bits are lost or duplicated.
    - A complete word may transfer in the same cycle the held word is accepted (zero bubble).
  - DRAIN: generation is finished and the final word is pending. The final handshake → IDLE, and busy=0 in the next cycle.
- Throughput: one keystream bit per cycle with out_ready held high.
- First out_valid occurs 1+KEY_BITS+FRAME_BITS+MIX_CYCLES+OUT_WIDTH cycles after the start-accept edge (195 at defaults).
- Word count per burst = ceil(BURST_BITS/OUT_WIDTH).
- out_data, out_last and out_valid are registered. While out_valid=1 and out_ready=0, they are held stable.
- abort (any state) → IDLE next cycle: out_valid=0, out_last=0, busy=0, counters cleared. abort has priority over start in the same cycle.
- Asynchronous reset mid-burst behaves identically to power-on reset.
- Counters are sized with $clog2 of their maximum counts. No counter wraps: the bit counter saturates at BURST_BITS.

Test Plan:
- Golden vector, defaults:
  - Stimulus: key=64'hEFCDAB8967452312 (byte 0x12 in bits 7:0), frame=22'h134, out_ready=1.
  - The first 114 bits, repacked MSB-first into bytes, equal 53 4E AA 58 2F E8 15 1A B6 E1 85 5A 72 8C 00.
  - First two out_data words are 0xCA and 0x72.
  - First out_valid occurs 195 cycles after the start edge.
- Partial last word, defaults:
  - 29 words total.
  - Word 29 has out_last=1 and bits[7:4]=0.
  - busy falls the cycle after the word 29 handshake.
- Backpressure:
  - Random out_ready at about 30% duty.
  - The concatenated keystream matches the free-running run bit-for-bit.
  - out_data is stable whenever out_valid=1 and out_ready=0.
- Parameter sweep: OUT_WIDTH in {1, 5, 32}, BURST_BITS in {1, 114, 228}, MIX_CYCLES in {1, 100}.
  - The bitstream matches the C model.
  - Word count = ceil(BURST_BITS/OUT_WIDTH).
- Control edges:
  - start while busy has no effect on the stream.
  - abort during LOAD, MIX and RUN gives IDLE and out_valid=0 next cycle.
  - A following start produces the exact golden stream.
- Reset: assert reset_n low mid-RUN with out_valid=1.
  - All outputs drop to 0 immediately, without waiting for a clock edge.
  - The next start reproduces the golden vector.
